// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and width constants for the fetch path
package cpu_pkg;

   localparam int ADDR_W  = 16;
   localparam int INSTR_W = 16;

   localparam logic [ADDR_W-1:0] PC_STEP = 16'd2;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      HALT  = 2'd2
   } state_t;

   // Instructions are halfword aligned; bit 0 of any target is dropped.
   function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:1], 1'b0};
   endfunction

endpackage

// File: rtl/addsub_16bit.sv
// rtl/addsub_16bit.sv - 16-bit modulo adder/subtractor (result = a + b, or a - b when sub=1)
module addsub_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        sub,
   output logic [15:0] result
);

   assign result = a + (b ^ {16{sub}}) + {15'd0, sub};

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer: PC, imem request, decode buffer, redirect/halt
// Optional FETCH_STALL_CNT_EN adds the stall_cnt output (memory wait-cycle counter).
module fetch_ctrl
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_ready,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc,
   input  logic               if_ready,
   input  logic               halt,
   input  logic               rd_valid,
   input  logic [ADDR_W-1:0]  rd_target,
`ifdef FETCH_STALL_CNT_EN
   output logic [15:0]        stall_cnt,
`endif
   output logic               halted
);

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] held_addr;
   logic [ADDR_W-1:0] rd_pc;
   logic              squash;

   addsub_16bit u_pc_inc (
      .a      (pc),
      .b      (PC_STEP),
      .sub    (1'b0),
      .result (pc_inc)
   );

   assign rd_pc = align_pc(rd_target);

   // A squashed request keeps its original address until the memory completes it.
   assign imem_addr = squash ? held_addr : pc;
   assign imem_req  = ~rst & (state == FETCH);
   assign if_valid  = ~rst & (state == HOLD);
   assign halted    = ~rst & (state == HALT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         held_addr <= RESET_PC;
         squash    <= 1'b0;
         if_instr  <= '0;
         if_pc     <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (imem_ready) begin
                  if (squash || rd_valid) begin
                     squash <= 1'b0;
                     if (rd_valid) pc <= rd_pc;
                  end else begin
                     if_instr <= imem_rdata;
                     if_pc    <= pc;
                     pc       <= pc_inc;
                     state    <= HOLD;
                  end
               end else if (rd_valid) begin
                  pc     <= rd_pc;
                  squash <= 1'b1;
                  if (!squash) held_addr <= pc;
               end
            end
            HOLD: begin
               if (rd_valid) begin
                  pc    <= rd_pc;
                  state <= FETCH;
               end else if (if_ready) begin
                  state <= halt ? HALT : FETCH;
               end
            end
            HALT: begin
            end
            default: state <= FETCH;
         endcase
      end
   end

`ifdef FETCH_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (state == FETCH && !imem_ready && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the 16-bit CPU. It owns the architectural PC register and issues requests to a multi-cycle instruction memory. It presents each fetched instruction and its PC to decode with a valid/ready handshake. It applies redirects from the branch-resolution logic (the PC-select output for taken b/br) and stops fetching when a halt is decoded.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset; bit 0 must be 0
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request, held until imem_ready
- imem_addr  out  16  fetch address; stable while imem_req=1
- imem_rdata  in  16  instruction word; sampled only when imem_ready=1
- imem_ready  in  1  memory completes the outstanding request this cycle
- if_valid  out  1  if_instr/if_pc hold a valid instruction
- if_instr  out  16  buffered instruction
- if_pc  out  16  address of if_instr
- if_ready  in  1  decode accepts the instruction this cycle
- halt  in  1  decode reports that if_instr is hlt; meaningful only with if_valid&if_ready
- rd_valid  in  1  redirect the PC; level, one cycle per redirect
- rd_target  in  16  redirect target; bit 0 forced to 0 internally
- halted  out  1  block is in HALT

## Operation
- Registers:
  - pc: the next fetch address.
  - squash: the outstanding response must be discarded.
  - the instruction buffer: if_instr, if_pc.
  - state.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
    - imem_ready & ~squash & ~rd_valid: capture the buffer (if_instr<=imem_rdata, if_pc<=pc), pc<=pc+2, go to HOLD.
    - imem_ready & (squash | rd_valid): discard the data, clear squash, stay in FETCH. The next request uses the redirect target.
    - ~imem_ready & rd_valid: squash<=1. The request stays on the old address until ready.
  - HOLD: if_valid=1, imem_req=0.
    - rd_valid: drop the instruction, go to FETCH. Redirect has priority over if_ready and halt.
    - if_ready & halt: go to HALT.
    - if_ready & ~halt: go to FETCH.
  - HALT: no requests, if_valid=0, halted=1. rd_valid is ignored. Only rst exits HALT.
- Redirect in any non-HALT state: pc<={rd_target[15:1],1'b0}. With a squash pending, the latest redirect wins.
- PC arithmetic: 16-bit modulo, so 16'hFFFE+2 = 16'h0000. There is no overflow indication.
- Throughput: at most one instruction per 2 cycles (FETCH then HOLD). This is acceptable for this core.

## Timing
- During rst: state<=FETCH, pc<=RESET_PC, squash<=0, if_instr<=0, if_pc<=0.
- Outputs while rst=1: imem_req=0, if_valid=0, halted=0.
- First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC.
- imem_ready in cycle N → if_valid=1 in cycle N+1 (registered, no combinational memory-to-decode path).
- imem_ready may be asserted in the same cycle as imem_req, giving a 0-wait fetch.
- if_ready in cycle N while in HOLD → imem_req=1 in cycle N+1 with the updated pc.
- rd_valid in cycle N → the next new request or held request abandonment happens in N+1; if_valid=0 from N+1.
- halt in cycle N with if_valid&if_ready → halted=1 and imem_req=0 from cycle N+1.
- rst in any state, including mid-request or with a squash pending: return to reset values next cycle. The memory side must tolerate an abandoned request.

## Configuration
- FETCH_STALL_CNT_EN
  - Defined: adds output stall_cnt (out, 16). It counts cycles in FETCH with imem_req=1 & ~imem_ready. It saturates at 16'hFFFF, clears on rst and freezes in HALT.
  - Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package cpu_pkg:
  - state enum {FETCH, HOLD, HALT}.
  - width constants: ADDR_W=16, INSTR_W=16.
  - PC_STEP=16'd2.
- Sub-module: the PC+2 increment reuses the existing addsub_16bit (sub=0, B=PC_STEP). The state machine and buffer live in fetch_ctrl.

## Test plan
- Reset, then 0-wait memory, if_ready=1: imem_addr sequence 0000,0002,0004; if_pc matches; if_valid every other cycle.
- Memory with 3 wait cycles, and decode holds if_ready=0 for 4 cycles: imem_addr stable through the waits; if_instr stable through the stall; no duplicate or lost instruction.
- rd_valid with rd_target=16'h0041 during a FETCH wait: the old address is held until ready, its data is discarded, the next imem_addr=0040, and if_valid never rises for the discarded word.
- rd_valid and if_ready&halt in the same HOLD cycle: redirect wins; halted stays 0; fetch proceeds at the target.
- halt accepted at if_pc=0006: halted=1 next cycle; no further imem_req despite rd_valid; rst returns imem_addr=RESET_PC.
- pc=FFFE fetch completes: next imem_addr=0000. With FETCH_STALL_CNT_EN, 5 wait cycles → stall_cnt=5.
